// File: rtl/data_cache_line_wt.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_line_wt
// Purpose  : Direct-mapped write-through, no-write-allocate data cache with
//            multi-word lines, byte-granular writes and a kseg1 bypass.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache_line_wt #(
    parameter int A_WIDTH     = 32,
    parameter int C_INDEX     = 6,
    parameter int L_OFFSET    = 2,
    parameter int UNCACHED_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] p_a,
    input  logic [31:0]        p_dout,
    output logic [31:0]        p_din,
    input  logic               p_strobe,
    input  logic               p_rw,
    input  logic [3:0]         p_wen,
    input  logic [3:0]         p_ren,
    output logic               p_ready,
    output logic [A_WIDTH-1:0] m_a,
    input  logic [31:0]        m_dout,
    output logic [31:0]        m_din,
    output logic               m_strobe,
    output logic               m_rw,
    input  logic               m_ready,
    output logic [1:0]         m_size
);

    localparam int c_LINES   = 1 << C_INDEX;
    localparam int c_WORDS   = 1 << L_OFFSET;
    localparam int c_IDX_LSB = L_OFFSET + 2;
    localparam int c_TAG_LSB = C_INDEX + L_OFFSET + 2;
    localparam int c_TAG_W   = A_WIDTH - c_TAG_LSB;

    localparam logic [L_OFFSET-1:0] c_LAST_WORD = '1;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_REFILL   = 2'd1;
    localparam logic [1:0] c_WRITE    = 2'd2;
    localparam logic [1:0] c_UNCACHED = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next;

    logic [A_WIDTH-1:0]  r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wen;
    logic [3:0]          r_ren;
    logic [L_OFFSET-1:0] r_cnt;

    logic [c_LINES-1:0]  r_valid;
    logic [c_TAG_W-1:0]  r_tag  [c_LINES];
    logic [31:0]         r_data [c_LINES*c_WORDS];

    logic [c_TAG_W-1:0]  w_p_tag;
    logic [C_INDEX-1:0]  w_p_idx;
    logic [L_OFFSET-1:0] w_p_word;
    logic                w_p_uncached;
    logic                w_hit;
    logic [31:0]         w_hit_word;

    logic [c_TAG_W-1:0]  w_r_tag;
    logic [C_INDEX-1:0]  w_r_idx;
    logic [L_OFFSET-1:0] w_r_word;
    logic                w_r_uncached;
    logic                w_line_match;
    logic [31:0]         w_cur_word;
    logic [31:0]         w_merged;
    logic                w_leave_idle;
    logic                w_refill_beat;

    function automatic logic [1:0] f_size(input logic [3:0] en);
        case (en)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: f_size = 2'b00;
            4'b0011, 4'b1100:                   f_size = 2'b01;
            default:                            f_size = 2'b10;
        endcase
    endfunction

    // CPU-side lookup (live address) and request-side lookup (captured address)
    assign w_p_tag      = p_a[A_WIDTH-1:c_TAG_LSB];
    assign w_p_idx      = p_a[c_TAG_LSB-1:c_IDX_LSB];
    assign w_p_word     = p_a[c_IDX_LSB-1:2];
    assign w_p_uncached = (UNCACHED_EN != 0) && (p_a[A_WIDTH-1 -: 3] == 3'b101);
    assign w_hit_word   = r_data[{w_p_idx, w_p_word}];
    assign w_hit        = p_strobe && !p_rw && !w_p_uncached
                          && r_valid[w_p_idx] && (r_tag[w_p_idx] == w_p_tag);

    assign w_r_tag      = r_addr[A_WIDTH-1:c_TAG_LSB];
    assign w_r_idx      = r_addr[c_TAG_LSB-1:c_IDX_LSB];
    assign w_r_word     = r_addr[c_IDX_LSB-1:2];
    assign w_r_uncached = (UNCACHED_EN != 0) && (r_addr[A_WIDTH-1 -: 3] == 3'b101);
    assign w_line_match = !w_r_uncached && r_valid[w_r_idx] && (r_tag[w_r_idx] == w_r_tag);
    assign w_cur_word   = r_data[{w_r_idx, w_r_word}];

    assign w_leave_idle  = (r_state == c_IDLE) && (w_next != c_IDLE);
    assign w_refill_beat = (r_state == c_REFILL) && m_ready;

    always_comb begin
        w_merged = w_cur_word;
        for (int b = 0; b < 4; b++) begin
            if (r_wen[b]) begin
                w_merged[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (p_strobe) begin
                    if (p_rw) begin
                        w_next = c_WRITE;
                    end else if (w_p_uncached) begin
                        w_next = c_UNCACHED;
                    end else if (!w_hit) begin
                        w_next = c_REFILL;
                    end
                end
            end
            c_REFILL: begin
                if (m_ready && (r_cnt == c_LAST_WORD)) begin
                    w_next = c_IDLE;
                end
            end
            c_WRITE, c_UNCACHED: begin
                if (m_ready) begin
                    w_next = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        p_ready  = 1'b0;
        p_din    = 32'd0;
        m_strobe = 1'b0;
        m_rw     = 1'b0;
        m_size   = 2'b10;
        m_a      = r_addr;
        m_din    = r_wdata;
        case (r_state)
            c_IDLE: begin
                if (w_hit) begin
                    p_ready = 1'b1;
                    p_din   = w_hit_word;
                end
            end
            c_REFILL: begin
                m_strobe = 1'b1;
                m_a      = {r_addr[A_WIDTH-1:c_IDX_LSB], r_cnt, 2'b00};
            end
            c_WRITE: begin
                m_strobe = 1'b1;
                m_rw     = 1'b1;
                m_size   = f_size(r_wen);
                p_ready  = m_ready;
            end
            c_UNCACHED: begin
                m_strobe = 1'b1;
                m_size   = f_size(r_ren);
                p_ready  = m_ready;
                p_din    = m_ready ? m_dout : 32'd0;
            end
            default: begin
                p_ready = 1'b0;
            end
        endcase
    end

    // Request capture, beat counter and valid bits; valid drops on the first
    // refill beat so a half-filled line can never produce a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= '0;
            r_ren   <= '0;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            if (w_leave_idle) begin
                r_addr  <= p_a;
                r_wdata <= p_dout;
                r_wen   <= p_wen;
                r_ren   <= p_ren;
                r_cnt   <= '0;
            end
            if (w_refill_beat) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == '0) begin
                    r_valid[w_r_idx] <= 1'b0;
                end
                if (r_cnt == c_LAST_WORD) begin
                    r_valid[w_r_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_refill_beat) begin
            r_data[{w_r_idx, r_cnt}] <= m_dout;
            if (r_cnt == c_LAST_WORD) begin
                r_tag[w_r_idx] <= w_r_tag;
            end
        end
        if ((r_state == c_WRITE) && m_ready && w_line_match) begin
            r_data[{w_r_idx, w_r_word}] <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache_line_wt.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache_line_wt
// Purpose  : Directed self-checking bench for data_cache_line_wt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache_line_wt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] p_a = '0;
    logic [31:0] p_dout = '0;
    logic [31:0] p_din;
    logic        p_strobe = 1'b0;
    logic        p_rw = 1'b0;
    logic [3:0]  p_wen = '0;
    logic [3:0]  p_ren = 4'hF;
    logic        p_ready;
    logic [31:0] m_a;
    logic [31:0] m_dout = '0;
    logic [31:0] m_din;
    logic        m_strobe;
    logic        m_rw;
    logic        m_ready = 1'b0;
    logic [1:0]  m_size;

    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    int wait_cnt = 0;
    int strobe_cyc = 0;
    int stall_glitch = 0;
    logic        stalled_prev = 1'b0;
    logic [31:0] stalled_a = '0;

    logic [31:0] log_a   [$];
    logic        log_rw  [$];
    logic [1:0]  log_sz  [$];
    logic [31:0] log_din [$];

    data_cache_line_wt #(
        .A_WIDTH(32), .C_INDEX(6), .L_OFFSET(2), .UNCACHED_EN(1)
    ) dut (
        .clk(clk), .rst(rst),
        .p_a(p_a), .p_dout(p_dout), .p_din(p_din), .p_strobe(p_strobe),
        .p_rw(p_rw), .p_wen(p_wen), .p_ren(p_ren), .p_ready(p_ready),
        .m_a(m_a), .m_dout(m_dout), .m_din(m_din), .m_strobe(m_strobe),
        .m_rw(m_rw), .m_ready(m_ready), .m_size(m_size)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a[31:29] == 3'b101)      mem_rd = 32'hDEAD_BEEF;
        else if (a[31:4] == 28'h10)  mem_rd = 32'h11 * (32'(a[3:2]) + 32'd1);
        else                         mem_rd = a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: answers after mem_wait idle cycles per beat
    always @(posedge clk) begin
        #1;
        if (m_strobe) begin
            if (wait_cnt < mem_wait) begin
                m_ready  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end else begin
                m_ready  = 1'b1;
                wait_cnt = 0;
            end
        end else begin
            m_ready  = 1'b0;
            wait_cnt = 0;
        end
        m_dout = m_ready ? mem_rd(m_a) : 32'h0BAD_0000;
    end

    always @(negedge clk) begin
        if (m_strobe) strobe_cyc = strobe_cyc + 1;
        if (m_strobe && m_ready) begin
            log_a.push_back(m_a);
            log_rw.push_back(m_rw);
            log_sz.push_back(m_size);
            log_din.push_back(m_din);
        end
        if (m_strobe && stalled_prev && (m_a !== stalled_a)) stall_glitch = stall_glitch + 1;
        stalled_prev = m_strobe && !m_ready;
        stalled_a    = m_a;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_a.delete();
        log_rw.delete();
        log_sz.delete();
        log_din.delete();
    endtask

    task automatic cpu_req(input string tag, input logic rw, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] wen, input logic [3:0] ren,
                           output logic [31:0] rdata, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        rdata = '0;
        @(posedge clk); #1;
        p_a = a; p_dout = d; p_rw = rw; p_wen = wen; p_ren = ren; p_strobe = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (p_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            cyc = cyc + 1;
        end
        rdata = p_din;
        check({tag, "_done"}, {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        p_strobe = 1'b0;
    endtask

    task automatic check_refill(input string tag, input logic [31:0] base);
        check({tag, "_beats"}, 32'(log_a.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_a.size(); i++) begin
            check({tag, "_addr"}, log_a[i], base + 32'(4 * i));
            check({tag, "_rw_size"}, {29'd0, log_rw[i], log_sz[i]}, {29'd0, 1'b0, 2'b10});
        end
    endtask

    initial begin
        logic [31:0] rd;
        int cyc;
        int s0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_p_ready", {31'd0, p_ready}, 32'd0);
        check("rst_m_strobe", {31'd0, m_strobe}, 32'd0);
        check("rst_m_rw", {31'd0, m_rw}, 32'd0);
        check("rst_m_size", {30'd0, m_size}, 32'd2);
        check("rst_m_a", m_a, 32'd0);
        check("rst_m_din", m_din, 32'd0);
        check("rst_p_din", p_din, 32'd0);

        // Read miss: four-beat refill, hit one cycle after return
        clear_log();
        cpu_req("rd100", 1'b0, 32'h100, 32'd0, 4'h0, 4'hF, rd, cyc);
        check("rd100_data", rd, 32'h11);
        check("rd100_lat", 32'(cyc), 32'd5);
        check_refill("rd100", 32'h100);

        clear_log();
        s0 = strobe_cyc;
        cpu_req("rd108", 1'b0, 32'h108, 32'd0, 4'h0, 4'hF, rd, cyc);
        check("rd108_data", rd, 32'h33);
        check("rd108_lat", 32'(cyc), 32'd0);
        check("rd108_no_mem", 32'(strobe_cyc - s0), 32'd0);

        // Byte write hit, then half-word and empty-enable writes
        clear_log();
        cpu_req("wr104", 1'b1, 32'h104, 32'h0000_AB00, 4'b0010, 4'hF, rd, cyc);
        check("wr104_lat", 32'(cyc), 32'd1);
        check("wr104_beats", 32'(log_a.size()), 32'd1);
        check("wr104_addr", log_a[0], 32'h104);
        check("wr104_rw_size", {29'd0, log_rw[0], log_sz[0]}, {29'd0, 1'b1, 2'b00});
        check("wr104_din", log_din[0], 32'h0000_AB00);
        cpu_req("rd104a", 1'b0, 32'h104, 32'd0, 4'h0, 4'hF, rd, cyc);
        check("rd104a_data", rd, 32'h0000_AB22);
        check("rd104a_lat", 32'(cyc), 32'd0);

        clear_log();
        cpu_req("wr104h", 1'b1, 32'h104, 32'h1234_5678, 4'b1100, 4'hF, rd, cyc);
        cpu_req("wr104z", 1'b1, 32'h104, 32'hFFFF_FFFF, 4'b0000, 4'hF, rd, cyc);
        check("wr104hz_beats", 32'(log_a.size()), 32'd2);
        check("wr104h_size", {30'd0, log_sz[0]}, 32'd1);
        check("wr104z_size", {30'd0, log_sz[1]}, 32'd2);
        cpu_req("rd104b", 1'b0, 32'h104, 32'd0, 4'h0, 4'hF, rd, cyc);
        check("rd104b_data", rd, 32'h1234_AB22);
        cpu_req("rd100b", 1'b0, 32'h100, 32'd0, 4'h0, 4'hF, rd, cyc);
        check("rd100b_data", rd, 32'h11);

        // Write miss: no allocation
        clear_log();
        mem_wait = 2;
        cpu_req("wr2000", 1'b1, 32'h2000, 32'hCAFE_F00D, 4'b1111, 4'hF, rd, cyc);
        check("wr2000_lat", 32'(cyc), 32'd3);
        check("wr2000_beats", 32'(log_a.size()), 32'd1);
        check("wr2000_rw_size", {29'd0, log_rw[0], log_sz[0]}, {29'd0, 1'b1, 2'b10});
        mem_wait = 0;
        clear_log();
        cpu_req("rd2000", 1'b0, 32'h2000, 32'd0, 4'h0, 4'hF, rd, cyc);
        check("rd2000_lat", 32'(cyc), 32'd5);
        check("rd2000_data", rd, 32'h5A5A_2000);
        check_refill("rd2000", 32'h2000);

        // Uncached reads always go to memory
        clear_log();
        mem_wait = 3;
        cpu_req("unc1", 1'b0, 32'hA000_0010, 32'd0, 4'h0, 4'b1111, rd, cyc);
        check("unc1_data", rd, 32'hDEAD_BEEF);
        check("unc1_lat", 32'(cyc), 32'd4);
        check("unc1_beats", 32'(log_a.size()), 32'd1);
        check("unc1_addr", log_a[0], 32'hA000_0010);
        check("unc1_rw_size", {29'd0, log_rw[0], log_sz[0]}, {29'd0, 1'b0, 2'b10});
        mem_wait = 0;
        clear_log();
        cpu_req("unc2", 1'b0, 32'hA000_0010, 32'd0, 4'h0, 4'b0011, rd, cyc);
        check("unc2_data", rd, 32'hDEAD_BEEF);
        check("unc2_lat", 32'(cyc), 32'd1);
        check("unc2_size", {30'd0, log_sz[0]}, 32'd1);

        // Reset during the second refill beat
        @(posedge clk); #1;
        p_a = 32'h300; p_rw = 1'b0; p_strobe = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; p_strobe = 1'b0;
        @(negedge clk);
        check("rstmid_strobe", {31'd0, m_strobe}, 32'd1);
        check("rstmid_addr", m_a, 32'h304);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_after_strobe", {31'd0, m_strobe}, 32'd0);
        check("rstmid_after_ready", {31'd0, p_ready}, 32'd0);
        cpu_req("rd108r", 1'b0, 32'h108, 32'd0, 4'h0, 4'hF, rd, cyc);
        check("rd108r_lat", 32'(cyc), 32'd5);
        check("rd108r_data", rd, 32'h33);
        clear_log();
        cpu_req("rd300", 1'b0, 32'h300, 32'd0, 4'h0, 4'hF, rd, cyc);
        check("rd300_lat", 32'(cyc), 32'd5);
        check("rd300_data", rd, 32'h5A5A_0300);
        check_refill("rd300", 32'h300);

        // Stalled refill: address must hold on each waiting beat
        clear_log();
        mem_wait = 5;
        stall_glitch = 0;
        cpu_req("rd400", 1'b0, 32'h400, 32'd0, 4'h0, 4'hF, rd, cyc);
        check("rd400_lat", 32'(cyc), 32'd25);
        check("rd400_data", rd, 32'h5A5A_0400);
        check("rd400_stable", 32'(stall_glitch), 32'd0);
        check_refill("rd400", 32'h400);
        mem_wait = 0;
        cpu_req("rd40c", 1'b0, 32'h40C, 32'd0, 4'h0, 4'hF, rd, cyc);
        check("rd40c_data", rd, 32'h5A5A_040C);
        check("rd40c_lat", 32'(cyc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
